// File: rtl/motor_step_ctrl_if.sv
// Command/status bundle of the stepper controller: motion commands in,
// coil pattern and status out.
interface motor_step_ctrl_if #(
    parameter int DW = 8
);
    logic          EN;
    logic          QR_in;
    logic [DW-1:0] geo_in;
    logic          geo_vld;
    logic [DW-1:0] gps_in;
    logic          gps_vld;
    logic [3:0]    M_OUT;
    logic          ro_motor;
    logic          dir;
    logic          busy;
    logic          done;

    modport master (
        output EN, QR_in, geo_in, geo_vld, gps_in, gps_vld,
        input  M_OUT, ro_motor, dir, busy, done
    );

    modport slave (
        input  EN, QR_in, geo_in, geo_vld, gps_in, gps_vld,
        output M_OUT, ro_motor, dir, busy, done
    );
endinterface

// File: rtl/motor_step_ctrl.sv
// Stepper motor sequencer: counted moves (geo/gps), continuous QR-scan
// rotation with a fixed tail, pause/resume, full- or half-step coil patterns.
module motor_step_ctrl #(
    parameter int DW      = 8,
    parameter int DIV     = 4,
    parameter int HALF    = 0,
    parameter int QR_TAIL = 8
) (
    input logic               PWM,
    input logic               RST,
    motor_step_ctrl_if.slave  bus
);
    localparam int CW  = DW - 1;
    localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = (QR_TAIL > 0) ? $clog2(QR_TAIL + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_CONT, S_TAIL, S_HOLD} state_t;

    state_t          state_q, state_d, ret_q, ret_d;
    logic [2:0]      phase_q, phase_d;
    logic [PSW-1:0]  presc_q, presc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tail_q, tail_d;
    logic            dir_q, dir_d;
    logic [3:0]      m_out_q, m_out_d;
    logic            ro_q, ro_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            step;
    logic            presc_wrap;
    logic            unused_gps_sign;

    assign unused_gps_sign = bus.gps_in[DW-1];

    function automatic logic [3:0] phase_pat(input logic [2:0] ph);
        logic [3:0] p;
        if (HALF != 0) begin
            case (ph)
                3'd0:    p = 4'b0001;
                3'd1:    p = 4'b0011;
                3'd2:    p = 4'b0010;
                3'd3:    p = 4'b0110;
                3'd4:    p = 4'b0100;
                3'd5:    p = 4'b1100;
                3'd6:    p = 4'b1000;
                default: p = 4'b1001;
            endcase
        end else begin
            case (ph[1:0])
                2'd0:    p = 4'b0001;
                2'd1:    p = 4'b0010;
                2'd2:    p = 4'b0100;
                default: p = 4'b1000;
            endcase
        end
        return p;
    endfunction

    // Full-step wraps modulo 4 by clearing the top bit of the 3-bit index.
    function automatic logic [2:0] next_phase(input logic [2:0] ph, input logic up);
        logic [2:0] n;
        n = up ? ph + 3'd1 : ph - 3'd1;
        if (HALF == 0) n[2] = 1'b0;
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        phase_d    = phase_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        tail_d     = tail_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        step       = 1'b0;
        presc_wrap = (presc_q == PSW'(DIV - 1));

        case (state_q)
            S_IDLE: begin
                if (bus.EN) begin
                    if (bus.QR_in) begin
                        dir_d   = 1'b1;
                        presc_d = '0;
                        state_d = S_CONT;
                    end else if (bus.geo_vld) begin
                        dir_d = ~bus.geo_in[DW-1];
                        cnt_d = bus.geo_in[DW-2:0];
                        if (bus.geo_in[DW-2:0] == '0) begin
                            done_d = 1'b1;
                        end else begin
                            presc_d = '0;
                            state_d = S_MOVE;
                        end
                    end else if (bus.gps_vld) begin
                        dir_d = 1'b1;
                        cnt_d = bus.gps_in[DW-2:0];
                        if (bus.gps_in[DW-2:0] == '0) begin
                            done_d = 1'b1;
                        end else begin
                            presc_d = '0;
                            state_d = S_MOVE;
                        end
                    end
                end
            end
            S_MOVE: begin
                if (!bus.EN) begin
                    ret_d   = S_MOVE;
                    state_d = S_HOLD;
                end else if (presc_wrap) begin
                    step    = 1'b1;
                    presc_d = '0;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PSW'(1);
                end
            end
            S_CONT: begin
                if (!bus.EN) begin
                    ret_d   = S_CONT;
                    state_d = S_HOLD;
                end else if (!bus.QR_in) begin
                    // Prescaler is kept so the tail continues the running cadence.
                    if (QR_TAIL == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tail_d  = TW'(QR_TAIL);
                        state_d = S_TAIL;
                    end
                end else if (presc_wrap) begin
                    step    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PSW'(1);
                end
            end
            S_TAIL: begin
                if (!bus.EN) begin
                    ret_d   = S_TAIL;
                    state_d = S_HOLD;
                end else if (presc_wrap) begin
                    step    = 1'b1;
                    presc_d = '0;
                    tail_d  = tail_q - TW'(1);
                    if (tail_q == TW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PSW'(1);
                end
            end
            S_HOLD: begin
                if (bus.EN) state_d = ret_q;
            end
            default: state_d = S_IDLE;
        endcase

        if (step) phase_d = next_phase(phase_q, dir_q);

        m_out_d = (state_d == S_IDLE) ? 4'b0000 : phase_pat(phase_d);
        ro_d    = (state_d == S_MOVE) || (state_d == S_CONT) || (state_d == S_TAIL);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge PWM or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            phase_q <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            tail_q  <= '0;
            dir_q   <= 1'b0;
            m_out_q <= 4'b0000;
            ro_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            phase_q <= phase_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
            dir_q   <= dir_d;
            m_out_q <= m_out_d;
            ro_q    <= ro_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.M_OUT    = m_out_q;
    assign bus.ro_motor = ro_q;
    assign bus.dir      = dir_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_motor_step_ctrl.sv
// Directed bench for motor_step_ctrl (DW=8, DIV=4, HALF=0, QR_TAIL=8):
// table of counted moves plus hand-written reset, pause, QR and priority sequences.
module tb_motor_step_ctrl;
    logic PWM;
    logic RST;

    motor_step_ctrl_if #(.DW(8)) bus ();

    motor_step_ctrl #(.DW(8), .DIV(4), .HALF(0), .QR_TAIL(8)) dut (
        .PWM (PWM),
        .RST (RST),
        .bus (bus)
    );

    initial PWM = 1'b0;
    always #5 PWM = ~PWM;

    typedef struct {
        int         kind;      // 0 geo, 1 gps
        logic [7:0] data;
        int         exp_dir;
        int         exp_n;
        logic [3:0] exp_first;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int ph       = 0;
    logic [3:0] full_pat [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int adv(input int p, input int d);
        return (d != 0) ? (p + 1) % 4 : (p + 3) % 4;
    endfunction

    task automatic issue(input int kind, input logic [7:0] data);
        @(negedge PWM);
        case (kind)
            0: begin bus.geo_in = data; bus.geo_vld = 1'b1; end
            1: begin bus.gps_in = data; bus.gps_vld = 1'b1; end
            2: bus.QR_in = 1'b1;
            default: begin
                bus.QR_in = 1'b1;
                bus.geo_in = 8'h03; bus.geo_vld = 1'b1;
                bus.gps_in = 8'h02; bus.gps_vld = 1'b1;
            end
        endcase
        @(posedge PWM); #1;
        bus.geo_vld = 1'b0;
        bus.gps_vld = 1'b0;
    endtask

    // Follows a running command to done, checking each observed pattern
    // against the phase model; the last step coincides with the return to idle.
    task automatic track(input int dir, input int en_off, input int en_on,
                         input int qr_off, input int poke,
                         output int steps, output int steps_qr, output int cyc);
        logic [3:0] prev;
        bit got_done;
        prev = bus.M_OUT; steps = 0; steps_qr = 0; cyc = 0; got_done = 0;
        while (!got_done && cyc < 2000) begin
            @(posedge PWM); #1;
            cyc++;
            if (bus.done) begin
                got_done = 1;
            end else if (bus.M_OUT != prev) begin
                steps++;
                ph = adv(ph, dir);
                check("step_pattern", int'(bus.M_OUT), int'(full_pat[ph]));
                prev = bus.M_OUT;
            end
            if (en_off > 0 && cyc == en_off + 8) begin
                check("hold_ro_motor", int'(bus.ro_motor), 0);
                check("hold_busy", int'(bus.busy), 1);
                check("hold_m_out", int'(bus.M_OUT), int'(prev));
            end
            if (cyc == qr_off) begin bus.QR_in = 1'b0; steps_qr = steps; end
            if (cyc == poke) begin bus.geo_in = 8'h05; bus.geo_vld = 1'b1; end
            if (cyc == poke + 1) bus.geo_vld = 1'b0;
            if (cyc == en_off) bus.EN = 1'b0;
            if (cyc == en_on) bus.EN = 1'b1;
        end
        check("done_seen", int'(got_done), 1);
        if (got_done) begin
            steps++;
            ph = adv(ph, dir);
        end
    endtask

    task automatic idle_after_done();
        check("idle_m_out", int'(bus.M_OUT), 0);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_ro_motor", int'(bus.ro_motor), 0);
        @(posedge PWM); #1;
        check("done_one_cycle", int'(bus.done), 0);
        check("stay_idle", int'(bus.busy), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int steps, sq, cyc;
        issue(v.kind, v.data);
        if (v.exp_n == 0) begin
            check("zero_done", int'(bus.done), 1);
            check("zero_busy", int'(bus.busy), 0);
            check("zero_m_out", int'(bus.M_OUT), 0);
            @(posedge PWM); #1;
            check("zero_done_clear", int'(bus.done), 0);
            check("zero_m_out_after", int'(bus.M_OUT), 0);
        end else begin
            check("accept_busy", int'(bus.busy), 1);
            check("accept_ro_motor", int'(bus.ro_motor), 1);
            check("accept_dir", int'(bus.dir), v.exp_dir);
            check("first_pattern", int'(bus.M_OUT), int'(v.exp_first));
            track(v.exp_dir, -1, -1, -1, -1, steps, sq, cyc);
            check("step_count", steps, v.exp_n);
            check("done_cycle", cyc, 4 * v.exp_n);
            idle_after_done();
        end
    endtask

    vec_t vecs [9];

    initial begin
        int steps, sq, cyc;
        vec_t rv;

        vecs[0] = '{0, 8'b0100_0110, 1, 70, 4'b0001};
        vecs[1] = '{0, 8'b1100_0110, 0, 70, 4'b0100};
        vecs[2] = '{1, 8'b1100_0110, 1, 70, 4'b0001};
        vecs[3] = '{0, 8'b1000_0000, 0, 0,  4'b0000};
        vecs[4] = '{1, 8'b0000_0011, 1, 3,  4'b0100};
        vecs[5] = '{0, 8'b1000_0101, 0, 5,  4'b0010};
        vecs[6] = '{0, 8'b0000_0001, 1, 1,  4'b0001};
        vecs[7] = '{0, 8'b1000_0001, 0, 1,  4'b0010};
        vecs[8] = '{0, 8'b1000_0010, 0, 2,  4'b0001};

        RST = 1'b1;
        bus.EN = 1'b1; bus.QR_in = 1'b0;
        bus.geo_in = '0; bus.geo_vld = 1'b0;
        bus.gps_in = '0; bus.gps_vld = 1'b0;
        repeat (3) @(posedge PWM);
        #1;
        check("rst_m_out", int'(bus.M_OUT), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ro_motor", int'(bus.ro_motor), 0);
        check("rst_dir", int'(bus.dir), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge PWM);
        RST = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Pause mid-interval after step 10 for 20 cycles; phase model now at 2.
        check("model_phase_before_hold", ph, 2);
        issue(0, 8'b0100_0110);
        check("hold_first_pattern", int'(bus.M_OUT), int'(full_pat[2]));
        track(1, 42, 62, -1, -1, steps, sq, cyc);
        check("hold_step_count", steps, 70);
        check("hold_done_cycle", cyc, 301);
        idle_after_done();

        // QR scan: 40 cycles of rotation, geo strobe while busy must be ignored.
        issue(2, 8'h00);
        check("qr_busy", int'(bus.busy), 1);
        check("qr_dir", int'(bus.dir), 1);
        check("qr_first_pattern", int'(bus.M_OUT), int'(full_pat[0]));
        track(1, -1, -1, 40, 20, steps, sq, cyc);
        check("qr_steps_during_scan", sq, 10);
        check("qr_total_steps", steps, 18);
        idle_after_done();

        // All three requests together: QR wins.
        issue(3, 8'h00);
        check("prio_dir", int'(bus.dir), 1);
        check("prio_busy", int'(bus.busy), 1);
        track(1, -1, -1, 20, -1, steps, sq, cyc);
        check("prio_steps_during_scan", sq, 5);
        check("prio_total_steps", steps, 13);
        idle_after_done();

        // Reset mid-move, then the next move starts from phase 0.
        issue(0, 8'b0100_0110);
        repeat (10) @(posedge PWM);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_m_out", int'(bus.M_OUT), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_ro_motor", int'(bus.ro_motor), 0);
        check("midrst_dir", int'(bus.dir), 0);
        @(negedge PWM);
        RST = 1'b0;
        ph = 0;
        rv = '{0, 8'b0000_0011, 1, 3, 4'b0001};
        run_vec(rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
